// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, samples combinational imem and registers instr/pc for decode.
// Optional FETCH_PERF_COUNTERS_EN adds fetch_count/stall_count outputs.
module fetch_unit #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter bit          START_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc,
  input  logic [31:0] instr,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [1:0]  state
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [63:0] fetch_count,
  output logic [63:0] stall_count
`endif
);

  // Handshake: decode takes the IF/ID word on any edge where out_valid && out_ready.
  // out_instr/out_pc never change while out_valid && !out_ready.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [63:0] pc_reg;
  logic        accept;
  logic        can_load;
  logic        flush;
  logic        capture;
  logic        clear_valid;

  assign accept   = out_valid && out_ready;
  assign can_load = !out_valid || out_ready;
  assign pc       = pc_reg;
  assign state    = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_ON_RESET ? ST_RUN : ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect freezes the state; start beats halt outside RUN.
  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      unique case (state_q)
        ST_RUN: begin
          if (halt) state_d = ST_HALTED;
        end
        ST_IDLE, ST_HALTED: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output/control decode for the datapath registers
  always_comb begin
    flush       = 1'b0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt) begin
            clear_valid = accept;
          end else if (can_load) begin
            capture = 1'b1;
          end
        end
        default: clear_valid = accept;
      endcase
    end
  end

  // PC and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 64'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
      pc_reg    <= redirect_pc & ~64'h3;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_instr <= instr;
      out_pc    <= pc_reg;
      pc_reg    <= pc_reg + 64'd4;
    end else if (clear_valid) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // A word handed over in the same cycle as a redirect is discarded, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 64'h0;
      stall_count <= 64'h0;
    end else begin
      if (accept && !redirect_valid) fetch_count <= fetch_count + 64'd1;
      if (state_q == ST_RUN && out_valid && !out_ready) stall_count <= stall_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: main instance plus wrap (RESET_PC=..FFFC) and idle-start instances.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  logic [95:0] exp_q[$];

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'd0:   imem = 32'h00106433;
      64'd4:   imem = 32'h0020e4b3;
      64'd8:   imem = 32'h0020f533;
      64'd12:  imem = 32'h003175b3;
      64'd16:  imem = 32'h00000633;
      default: imem = {a[29:0], 2'b11};
    endcase
  endfunction

  // Shared stimulus
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic        halt = 1'b0;
  logic        start = 1'b0;
  logic        redir = 1'b0;
  logic [63:0] redir_pc = 64'h0;
  logic        start_c = 1'b0;
  logic        zero = 1'b0;
  logic        one = 1'b1;
  logic [63:0] zero64 = 64'h0;

  // Instance A: defaults
  logic [63:0] pc_a, opc_a;
  logic [31:0] instr_a, oinstr_a;
  logic        valid_a;
  logic [1:0]  state_a;
  assign instr_a = imem(pc_a);

  // Instance B: wrap-around reset PC
  logic [63:0] pc_b, opc_b;
  logic [31:0] instr_b, oinstr_b;
  logic        valid_b;
  logic [1:0]  state_b;
  assign instr_b = imem(pc_b);

  // Instance C: leaves reset in IDLE
  logic [63:0] pc_c, opc_c;
  logic [31:0] instr_c, oinstr_c;
  logic        valid_c;
  logic [1:0]  state_c;
  assign instr_c = imem(pc_c);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [63:0] fcnt_a, scnt_a, fcnt_b, scnt_b, fcnt_c, scnt_c;
`endif

  fetch_unit u_a (
    .clk(clk), .rst(rst), .pc(pc_a), .instr(instr_a), .start(start), .halt(halt),
    .redirect_valid(redir), .redirect_pc(redir_pc), .out_valid(valid_a), .out_ready(ready),
    .out_instr(oinstr_a), .out_pc(opc_a), .state(state_a)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fcnt_a), .stall_count(scnt_a)
`endif
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_b (
    .clk(clk), .rst(rst), .pc(pc_b), .instr(instr_b), .start(zero), .halt(zero),
    .redirect_valid(zero), .redirect_pc(zero64), .out_valid(valid_b), .out_ready(one),
    .out_instr(oinstr_b), .out_pc(opc_b), .state(state_b)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fcnt_b), .stall_count(scnt_b)
`endif
  );

  fetch_unit #(.START_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst(rst), .pc(pc_c), .instr(instr_c), .start(start_c), .halt(zero),
    .redirect_valid(zero), .redirect_pc(zero64), .out_valid(valid_c), .out_ready(one),
    .out_instr(oinstr_c), .out_pc(opc_c), .state(state_c)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fcnt_c), .stall_count(scnt_c)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] a);
    exp_q.push_back({a, imem(a)});
  endtask

  // Scoreboard: a word handed to decode on the coming edge must match the queue head
  always @(negedge clk) begin
    logic [95:0] head;
    if (!rst && valid_a && ready && !redir) begin
      if (exp_q.size() == 0) begin
        chk("stream_unexpected", opc_a, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        head = exp_q.pop_front();
        chk("stream_pc", opc_a, head[95:32]);
        chk("stream_instr", {32'h0, oinstr_a}, {32'h0, head[31:0]});
      end
    end
  end

  // One clock edge; side instances B and C are checked against the edge number
  task automatic tick();
    @(posedge clk);
    #2;
    e++;
    if (e == 1) begin
      chk("wrap_first_pc", opc_b, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc_next", pc_b, 64'h0);
    end
    if (e == 2) begin
      chk("wrap_second_pc", opc_b, 64'h0);
      chk("wrap_second_instr", {32'h0, oinstr_b}, 64'h00106433);
    end
    if (e <= 10) chk("idle_valid", {63'h0, valid_c}, 64'h0);
    if (e == 10) begin
      chk("idle_state", {62'h0, state_c}, 64'h0);
      start_c = 1'b1;
    end
    if (e == 11) begin
      chk("idle_start_state", {62'h0, state_c}, 64'h1);
      chk("idle_start_valid", {63'h0, valid_c}, 64'h0);
      start_c = 1'b0;
    end
    if (e == 12) begin
      chk("idle_first_valid", {63'h0, valid_c}, 64'h1);
      chk("idle_first_pc", opc_c, 64'h0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {63'h0, valid_a}, 64'h0);
    chk("rst_instr", {32'h0, oinstr_a}, 64'h0);
    chk("rst_out_pc", opc_a, 64'h0);
    chk("rst_pc", pc_a, 64'h0);
    chk("rst_state", {62'h0, state_a}, 64'h1);
    chk("rst_state_idle", {62'h0, state_c}, 64'h0);
    rst = 1'b0;
    push(0); push(4); push(8); push(12); push(16);

    tick();
    chk("first_valid", {63'h0, valid_a}, 64'h1);
    chk("first_pc", opc_a, 64'h0);
    chk("first_instr", {32'h0, oinstr_a}, 64'h00106433);
    chk("first_next_pc", pc_a, 64'd4);
    tick();
    chk("second_pc", opc_a, 64'd4);
    tick();
    chk("third_pc", opc_a, 64'd8);
    chk("third_next_pc", pc_a, 64'd12);
    ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {63'h0, valid_a}, 64'h1);
      chk("stall_out_pc", opc_a, 64'd8);
      chk("stall_instr", {32'h0, oinstr_a}, 64'h0020f533);
      chk("stall_pc", pc_a, 64'd12);
    end
    ready = 1'b1;

    tick();
    chk("resume_pc", opc_a, 64'd12);
    chk("resume_instr", {32'h0, oinstr_a}, 64'h003175b3);
    tick();
    chk("fifth_pc", opc_a, 64'd16);
    tick();
    chk("sixth_pc", opc_a, 64'd20);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetch", fcnt_a, 64'd5);
    chk("perf_stall", scnt_a, 64'd3);
`endif
    redir = 1'b1;
    redir_pc = 64'd6;

    tick();
    chk("redir_valid", {63'h0, valid_a}, 64'h0);
    chk("redir_pc", pc_a, 64'd4);
    chk("redir_state", {62'h0, state_a}, 64'h1);
    redir = 1'b0;
    push(4);
    tick();
    chk("redir_out_pc", opc_a, 64'd4);
    chk("redir_instr", {32'h0, oinstr_a}, 64'h0020e4b3);
    chk("redir_next_pc", pc_a, 64'd8);
    push(8);
    tick();
    chk("pre_halt_pc", opc_a, 64'd8);
    halt = 1'b1;
    ready = 1'b0;

    tick();
    chk("halt_state", {62'h0, state_a}, 64'h2);
    chk("halt_valid_held", {63'h0, valid_a}, 64'h1);
    chk("halt_out_pc", opc_a, 64'd8);
    chk("halt_pc", pc_a, 64'd12);
    halt = 1'b0;
    tick();
    chk("halted_valid", {63'h0, valid_a}, 64'h1);
    chk("halted_state", {62'h0, state_a}, 64'h2);
    ready = 1'b1;
    tick();
    chk("halted_drain_valid", {63'h0, valid_a}, 64'h0);
    chk("halted_drain_pc", pc_a, 64'd12);
    start = 1'b1;
    halt = 1'b1;
    tick();
    chk("start_state", {62'h0, state_a}, 64'h1);
    chk("start_valid", {63'h0, valid_a}, 64'h0);
    chk("start_pc", pc_a, 64'd12);
    start = 1'b0;
    halt = 1'b0;
    tick();
    chk("restart_valid", {63'h0, valid_a}, 64'h1);
    chk("restart_out_pc", opc_a, 64'd12);
    chk("restart_pc", pc_a, 64'd16);
    ready = 1'b0;

    tick();
    chk("stall2_out_pc", opc_a, 64'd12);
    chk("stall2_pc", pc_a, 64'd16);
    rst = 1'b1;
    tick();
    chk("midrst_valid", {63'h0, valid_a}, 64'h0);
    chk("midrst_instr", {32'h0, oinstr_a}, 64'h0);
    chk("midrst_out_pc", opc_a, 64'h0);
    chk("midrst_pc", pc_a, 64'h0);
    chk("midrst_state", {62'h0, state_a}, 64'h1);
    rst = 1'b0;
    ready = 1'b1;

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
